zueirai_mem_arbiter: RTL and testbench

//  Arbitrates the single-port 256x8 data memory between three requesters:
//  CPU core (0), interrupt controller (1), IO block (2).

---
 rtl/zueirai_pkg.sv | 31 +++
 rtl/zueirai_rr_picker.sv | 35 +++
 rtl/zueirai_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_zueirai_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zueirai_pkg.sv
// Shared types and constants for the ZueiraI memory arbiter and its round-robin picker.
package zueirai_pkg;

    localparam int N_REQ = 3;
    localparam int AW    = 8;
    localparam int DW    = 8;

    // Requester indices on the arbiter ports
    localparam int REQ_CPU = 0;
    localparam int REQ_INT = 1;
    localparam int REQ_IO  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic int onehot_to_idx(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int k = 0; k < 32; k++) begin
            if (onehot[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/zueirai_rr_picker.sv
// Combinational round-robin picker: one-hot winner is the first set request at
// or above rr_ptr, wrapping modulo N_REQ. Shared with the interrupt controller.
module zueirai_rr_picker #(
    parameter int N_REQ = 3,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_rr_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic             o_any
);

    // Request vector duplicated so the upward scan from rr_ptr wraps without a modulo on the read side
    logic [2*N_REQ-1:0] w_req_dbl;

    assign w_req_dbl = {i_req, i_req};

    // Scan N_REQ positions starting at rr_ptr and keep the first hit
    always_comb begin : p_pick
        logic v_found;
        int   v_pos;
        v_found = 1'b0;
        v_pos   = 0;
        o_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_pos = (int'(i_rr_ptr) + k) % (2 * N_REQ);
            if (!v_found && w_req_dbl[v_pos]) begin
                o_win[v_pos % N_REQ] = 1'b1;
                v_found              = 1'b1;
            end
        end
        o_any = v_found;
    end

endmodule

// File: rtl/zueirai_mem_arbiter.sv
// Arbitrates the single-port data memory between CPU, interrupt controller and
// IO block. One access per slot; all memory-side signals are flop outputs so the
// edge-triggered memory only ever sees clean single-cycle strobes.
module zueirai_mem_arbiter #(
    parameter int N_REQ    = zueirai_pkg::N_REQ,
    parameter int AW       = zueirai_pkg::AW,
    parameter int DW       = zueirai_pkg::DW,
    parameter bit CPU_PRIO = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ-1:0]    i_we,
    input  logic [N_REQ*AW-1:0] i_addr,
    input  logic [N_REQ*DW-1:0] i_wdata,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_rvalid,
    output logic [DW-1:0]       o_rdata,
    output logic [AW-1:0]       o_mem_addr,
    output logic                o_mem_rd,
    output logic                o_mem_wr,
    output logic [DW-1:0]       o_mem_wdata,
    input  logic [DW-1:0]       i_mem_rdata
);

    import zueirai_pkg::*;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    w_rr_ptr_next;
    logic [N_REQ-1:0] r_win;
    logic [N_REQ-1:0] w_win_next;
    logic             r_we_l;
    logic             w_we_next;
    logic [AW-1:0]    r_addr_l;
    logic [AW-1:0]    w_addr_next;
    logic [DW-1:0]    r_wdata_l;
    logic [DW-1:0]    w_wdata_next;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_next;
    logic [N_REQ-1:0] r_rvalid;
    logic [N_REQ-1:0] w_rvalid_next;
    logic             r_mem_rd;
    logic             w_mem_rd_next;
    logic             r_mem_wr;
    logic             w_mem_wr_next;

    logic [N_REQ-1:0] w_rr_win;
    logic             w_rr_any;
    logic [N_REQ-1:0] w_pick;
    int               w_pick_idx;

    zueirai_rr_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .i_req    (i_req),
        .i_rr_ptr (r_rr_ptr),
        .o_win    (w_rr_win),
        .o_any    (w_rr_any)
    );

    // CPU override on top of the round-robin choice; req[CPU] implies w_rr_any, so "any" is shared
    always_comb begin
        w_pick = w_rr_win;
        if (CPU_PRIO && i_req[REQ_CPU]) begin
            w_pick          = '0;
            w_pick[REQ_CPU] = 1'b1;
        end
        w_pick_idx = onehot_to_idx(32'(w_pick));
    end

    // Next-state and next-output logic; strobes are computed here and registered below
    always_comb begin
        w_state_next  = r_state;
        w_rr_ptr_next = r_rr_ptr;
        w_win_next    = r_win;
        w_we_next     = r_we_l;
        w_addr_next   = r_addr_l;
        w_wdata_next  = r_wdata_l;
        w_gnt_next    = '0;
        w_rvalid_next = '0;
        w_mem_rd_next = 1'b0;
        w_mem_wr_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rr_any) begin
                    w_win_next    = w_pick;
                    w_we_next     = i_we[w_pick_idx];
                    w_addr_next   = i_addr[w_pick_idx*AW +: AW];
                    w_wdata_next  = i_wdata[w_pick_idx*DW +: DW];
                    w_gnt_next    = w_pick;
                    w_mem_wr_next = i_we[w_pick_idx];
                    w_mem_rd_next = !i_we[w_pick_idx];
                    // Pointer moves past every winner, CPU-priority wins included
                    w_rr_ptr_next = PW'((w_pick_idx + 1) % N_REQ);
                    w_state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we_l) begin
                    w_state_next = IDLE;
                end else begin
                    w_rvalid_next = r_win;
                    w_state_next  = WAIT;
                end
            end
            WAIT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latched request, round-robin pointer and registered outputs; reset kills any in-flight strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr  <= '0;
            r_win     <= '0;
            r_we_l    <= 1'b0;
            r_addr_l  <= '0;
            r_wdata_l <= '0;
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
        end else begin
            r_rr_ptr  <= w_rr_ptr_next;
            r_win     <= w_win_next;
            r_we_l    <= w_we_next;
            r_addr_l  <= w_addr_next;
            r_wdata_l <= w_wdata_next;
            r_gnt     <= w_gnt_next;
            r_rvalid  <= w_rvalid_next;
            r_mem_rd  <= w_mem_rd_next;
            r_mem_wr  <= w_mem_wr_next;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_rvalid    = r_rvalid;
    assign o_mem_addr  = r_addr_l;
    assign o_mem_wdata = r_wdata_l;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    // Memory read data is only meaningful in WAIT; hold zero otherwise
    assign o_rdata     = (r_state == WAIT) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_zueirai_mem_arbiter.sv
// Scoreboard bench for zueirai_mem_arbiter: instance 0 with CPU priority,
// instance 1 pure round-robin, each with a small synchronous memory model.
module tb_zueirai_mem_arbiter;

    import zueirai_pkg::*;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct {
        int         dut;
        logic [2:0] gnt;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         gap;
    } gexp_t;

    typedef struct {
        int         dut;
        logic [7:0] rdata;
    } rexp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req       [2];
    logic [2:0]  we        [2];
    logic [23:0] addr      [2];
    logic [23:0] wdata     [2];
    logic [2:0]  gnt       [2];
    logic [2:0]  rvalid    [2];
    logic [7:0]  rdata     [2];
    logic [7:0]  mem_addr  [2];
    logic        mem_rd    [2];
    logic        mem_wr    [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];

    int    checks;
    int    errors;
    cmd_t  cq [6][$];
    bit    act [6];
    gexp_t gq [$];
    rexp_t rq [$];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [7:0] mem [256];

        zueirai_mem_arbiter #(
            .N_REQ    (3),
            .AW       (8),
            .DW       (8),
            .CPU_PRIO (gi == 0)
        ) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_req       (req[gi]),
            .i_we        (we[gi]),
            .i_addr      (addr[gi]),
            .i_wdata     (wdata[gi]),
            .o_gnt       (gnt[gi]),
            .o_rvalid    (rvalid[gi]),
            .o_rdata     (rdata[gi]),
            .o_mem_addr  (mem_addr[gi]),
            .o_mem_rd    (mem_rd[gi]),
            .o_mem_wr    (mem_wr[gi]),
            .o_mem_wdata (mem_wdata[gi]),
            .i_mem_rdata (mem_rdata[gi])
        );

        always @(posedge clk) begin
            if (mem_wr[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
            if (mem_rd[gi]) mem_rdata[gi] <= mem[mem_addr[gi]];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic push_cmd(input int d, input int r, input logic w, input logic [7:0] a, input logic [7:0] wd);
        cmd_t c;
        c.we    = w;
        c.addr  = a;
        c.wdata = wd;
        cq[d*3+r].push_back(c);
    endtask

    task automatic exp_gnt(input int d, input int r, input logic w, input logic [7:0] a, input logic [7:0] wd, input int gap);
        gexp_t e;
        e.dut   = d;
        e.gnt   = 3'b001 << r;
        e.we    = w;
        e.addr  = a;
        e.wdata = wd;
        e.gap   = gap;
        gq.push_back(e);
    endtask

    task automatic exp_rd(input int d, input logic [7:0] data);
        rexp_t e;
        e.dut   = d;
        e.rdata = data;
        rq.push_back(e);
    endtask

    function automatic bit busy();
        bit b;
        b = (gq.size() != 0) || (rq.size() != 0);
        for (int s = 0; s < 6; s++) begin
            b = b || act[s] || (cq[s].size() != 0);
        end
        return b;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy() && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk_eq({"drain_", tag}, 32'(busy()), 32'(0));
        repeat (4) @(negedge clk);
    endtask

    // Requester models: hold a command until its grant, then present the next one
    initial begin
        cmd_t c;
        int   d;
        int   r;
        for (int k = 0; k < 2; k++) begin
            req[k]   = '0;
            we[k]    = '0;
            addr[k]  = '0;
            wdata[k] = '0;
        end
        for (int s = 0; s < 6; s++) act[s] = 1'b0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 6; s++) begin
                d = s / 3;
                r = s % 3;
                if (!rst_n) begin
                    act[s]    = 1'b0;
                    req[d][r] = 1'b0;
                end else begin
                    if (act[s] && gnt[d][r]) act[s] = 1'b0;
                    if (!act[s] && cq[s].size() != 0) begin
                        c                   = cq[s].pop_front();
                        act[s]              = 1'b1;
                        we[d][r]            = c.we;
                        addr[d][r*8 +: 8]   = c.addr;
                        wdata[d][r*8 +: 8]  = c.wdata;
                    end
                    req[d][r] = act[s];
                end
            end
        end
    end

    // Monitor: compares grants/strobes and read returns against the scoreboard
    initial begin
        gexp_t      e;
        rexp_t      x;
        int         cyc;
        int         last_cyc [2];
        logic [2:0] pend_rv  [2];
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            last_cyc[k] = 0;
            pend_rv[k]  = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rvalid[d] != '0 || pend_rv[d] != '0) begin
                    chk_eq("rvalid", 32'(rvalid[d]), 32'(pend_rv[d]));
                    if (pend_rv[d] != '0) begin
                        if (rq.size() == 0) begin
                            chk_eq("rq_size", 32'(rq.size()), 32'(1));
                        end else begin
                            x = rq.pop_front();
                            chk_eq("rdata_dut", 32'(d), 32'(x.dut));
                            chk_eq("rdata", 32'(rdata[d]), 32'(x.rdata));
                            $display("read  dut%0d rvalid=%b rdata=%02h cyc=%0d", d, rvalid[d], rdata[d], cyc);
                        end
                    end
                end
                pend_rv[d] = '0;
                if (gnt[d] != '0 || mem_rd[d] || mem_wr[d]) begin
                    if (gq.size() == 0) begin
                        chk_eq("spurious_gnt", 32'({gnt[d], mem_rd[d], mem_wr[d]}), 32'(0));
                    end else begin
                        e = gq.pop_front();
                        $display("grant dut%0d gnt=%b wr=%b rd=%b addr=%02h wdata=%02h cyc=%0d",
                                 d, gnt[d], mem_wr[d], mem_rd[d], mem_addr[d], mem_wdata[d], cyc);
                        chk_eq("gnt_dut", 32'(d), 32'(e.dut));
                        chk_eq("gnt", 32'(gnt[d]), 32'(e.gnt));
                        chk_eq("mem_wr", 32'(mem_wr[d]), 32'(e.we));
                        chk_eq("mem_rd", 32'(mem_rd[d]), 32'(!e.we));
                        chk_eq("mem_addr", 32'(mem_addr[d]), 32'(e.addr));
                        if (e.we) chk_eq("mem_wdata", 32'(mem_wdata[d]), 32'(e.wdata));
                        if (e.gap != 0) chk_eq("gnt_gap", 32'(cyc - last_cyc[d]), 32'(e.gap));
                        last_cyc[d] = cyc;
                        if (!e.we) pend_rv[d] = e.gnt;
                    end
                end
            end
        end
    end

    // Main test sequence
    initial begin
        int   n;
        logic seen;
        checks = 0;
        errors = 0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_eq("rst_gnt",       32'(gnt[d]),       32'(0));
            chk_eq("rst_rvalid",    32'(rvalid[d]),    32'(0));
            chk_eq("rst_mem_rd",    32'(mem_rd[d]),    32'(0));
            chk_eq("rst_mem_wr",    32'(mem_wr[d]),    32'(0));
            chk_eq("rst_mem_addr",  32'(mem_addr[d]),  32'(0));
            chk_eq("rst_mem_wdata", 32'(mem_wdata[d]), 32'(0));
            chk_eq("rst_rdata",     32'(rdata[d]),     32'(0));
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single write from the CPU
        push_cmd(0, REQ_CPU, 1'b1, 8'h10, 8'hA5);
        exp_gnt(0, REQ_CPU, 1'b1, 8'h10, 8'hA5, 0);
        drain("t1");

        // Seed 0x20 via IO, then read it back through the interrupt controller
        push_cmd(0, REQ_IO, 1'b1, 8'h20, 8'h3C);
        exp_gnt(0, REQ_IO, 1'b1, 8'h20, 8'h3C, 0);
        drain("t2_seed");
        push_cmd(0, REQ_INT, 1'b0, 8'h20, 8'h00);
        exp_gnt(0, REQ_INT, 1'b0, 8'h20, 8'h00, 0);
        exp_rd(0, 8'h3C);
        drain("t2");

        // Round-robin instance: IO fills 0x40..0x45 (pointer ends at 0)
        for (int k = 0; k < 6; k++) begin
            push_cmd(1, REQ_IO, 1'b1, 8'(8'h40 + k), 8'(8'h50 + k));
            exp_gnt(1, REQ_IO, 1'b1, 8'(8'h40 + k), 8'(8'h50 + k), (k == 0) ? 0 : 2);
        end
        drain("t3_seed");
        // All three reading continuously: 0,1,2,0,1,2, three cycles apart
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 3; r++) begin
                push_cmd(1, r, 1'b0, 8'(8'h40 + 3*k + r), 8'h00);
                exp_gnt(1, r, 1'b0, 8'(8'h40 + 3*k + r), 8'h00, (k == 0 && r == 0) ? 0 : 3);
                exp_rd(1, 8'(8'h50 + 3*k + r));
            end
        end
        drain("t3");

        // CPU priority: CPU wins every slot while requesting, then 1, then 2
        push_cmd(0, REQ_CPU, 1'b0, 8'h10, 8'h00);
        push_cmd(0, REQ_CPU, 1'b0, 8'h20, 8'h00);
        push_cmd(0, REQ_CPU, 1'b0, 8'h10, 8'h00);
        push_cmd(0, REQ_INT, 1'b0, 8'h20, 8'h00);
        push_cmd(0, REQ_IO,  1'b0, 8'h10, 8'h00);
        exp_gnt(0, REQ_CPU, 1'b0, 8'h10, 8'h00, 0); exp_rd(0, 8'hA5);
        exp_gnt(0, REQ_CPU, 1'b0, 8'h20, 8'h00, 3); exp_rd(0, 8'h3C);
        exp_gnt(0, REQ_CPU, 1'b0, 8'h10, 8'h00, 3); exp_rd(0, 8'hA5);
        exp_gnt(0, REQ_INT, 1'b0, 8'h20, 8'h00, 3); exp_rd(0, 8'h3C);
        exp_gnt(0, REQ_IO,  1'b0, 8'h10, 8'h00, 3); exp_rd(0, 8'hA5);
        drain("t4");

        // Back-to-back writes from IO: one every 2 cycles
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, REQ_IO, 1'b1, 8'(8'hF0 + k), 8'(k + 1));
            exp_gnt(0, REQ_IO, 1'b1, 8'(8'hF0 + k), 8'(k + 1), (k == 0) ? 0 : 2);
        end
        drain("t5");
        for (int k = 0; k < 4; k++) begin
            chk_eq("t5_mem", 32'(g_dut[0].mem[8'(8'hF0 + k)]), 32'(k + 1));
        end

        // Reset asserted during ISSUE of a read
        push_cmd(0, REQ_INT, 1'b0, 8'h10, 8'h00);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #2;
            seen = gnt[0][REQ_INT];
            n++;
        end
        chk_eq("t6_gnt_seen", 32'(seen), 32'(1));
        chk_eq("t6_mem_rd_pre", 32'(mem_rd[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_eq("t6_gnt",      32'(gnt[0]),      32'(0));
        chk_eq("t6_mem_rd",   32'(mem_rd[0]),   32'(0));
        chk_eq("t6_mem_wr",   32'(mem_wr[0]),   32'(0));
        chk_eq("t6_rvalid",   32'(rvalid[0]),   32'(0));
        chk_eq("t6_mem_addr", 32'(mem_addr[0]), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        // Pointer back at 0: INT (1) beats IO (2) when both request together
        push_cmd(0, REQ_INT, 1'b1, 8'h30, 8'h77);
        push_cmd(0, REQ_IO,  1'b1, 8'h31, 8'h88);
        exp_gnt(0, REQ_INT, 1'b1, 8'h30, 8'h77, 0);
        exp_gnt(0, REQ_IO,  1'b1, 8'h31, 8'h88, 2);
        drain("t6");
        chk_eq("t6_mem30", 32'(g_dut[0].mem[8'h30]), 32'(8'h77));
        chk_eq("t6_mem31", 32'(g_dut[0].mem[8'h31]), 32'(8'h88));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
